// File: rtl/npu8_pkg.sv
// Shared byte-datapath definitions for the quantized NPU adder stages.
package npu8_pkg;
  localparam int Q8_W        = 8;
  localparam int FRAME_CNT_W = 16;

  typedef logic [Q8_W-1:0]        q8_t;
  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

  // Next frame-counter value: returns to zero after the last pair, free-runs when len is zero.
  function automatic frame_cnt_t frame_cnt_next(input frame_cnt_t cnt, input frame_cnt_t len);
    if ((len != '0) && (cnt == len - frame_cnt_t'(1)))
      return '0;
    return cnt + frame_cnt_t'(1);
  endfunction

  function automatic logic frame_is_last(input frame_cnt_t cnt, input frame_cnt_t len);
    return (len != '0) && (cnt == len - frame_cnt_t'(1));
  endfunction
endpackage

// File: rtl/q_add8_pair_buf_if.sv
// Stream, control and status bundle of the residual-adder pairing buffer.
interface q_add8_pair_buf_if #(
  parameter int AW = 4
);
  import npu8_pkg::*;

  logic       FLUSH;
  logic       A_VALID;
  logic       A_READY;
  q8_t        A_DATA;
  logic       B_VALID;
  logic       B_READY;
  q8_t        B_DATA;
  frame_cnt_t FRAME_LEN;
  logic       OUT_EN;
  q8_t        OUT_A;
  q8_t        OUT_B;
  logic       FRAME_DONE;
  logic [AW:0] A_LEVEL;

  modport slave (
    input  FLUSH, A_VALID, A_DATA, B_VALID, B_DATA, FRAME_LEN,
    output A_READY, B_READY, OUT_EN, OUT_A, OUT_B, FRAME_DONE, A_LEVEL
  );

  modport master (
    output FLUSH, A_VALID, A_DATA, B_VALID, B_DATA, FRAME_LEN,
    input  A_READY, B_READY, OUT_EN, OUT_A, OUT_B, FRAME_DONE, A_LEVEL
  );
endinterface

// File: rtl/q_add8_pair_buf_fifo.sv
// Synchronous byte FIFO for the early skip stream; registered-head read, no fall-through.
// Caller guarantees no write when full and no read when empty; clr wins over both.
module pair_fifo
  import npu8_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        CLK,
  input  logic        RESET_X,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic        clr,
  input  q8_t         din,
  output q8_t         dout,
  output logic [AW:0] level
);
  q8_t mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level gates every read.
  always_ff @(posedge CLK) begin
    if (wr_en && !clr) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign level = level_q;
endmodule

// File: rtl/q_add8_pair_buf.sv
// Pairs the skip stream (A, FIFO-buffered) with the conv stream (B, 1-entry hold); 2-cycle accept-to-push.
// Optional Q_PAIR_STATS_EN adds STAT_PAIRS / STAT_A_HWM counters.
module q_add8_pair_buf
  import npu8_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         CLK,
  input  logic         RESET_X,
  q_add8_pair_buf_if.slave bus
`ifdef Q_PAIR_STATS_EN
  ,
  output logic [31:0]  STAT_PAIRS,
  output logic [AW:0]  STAT_A_HWM
`endif
);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic        flush;
  logic        a_push;
  logic        b_push;
  logic        pop;
  q8_t         fifo_dout;
  logic [AW:0] level;

  logic       b_vld_q,  b_vld_d;
  q8_t        b_dat_q,  b_dat_d;
  logic       out_en_q, out_en_d;
  q8_t        out_a_q,  out_a_d;
  q8_t        out_b_q,  out_b_d;
  logic       done_q,   done_d;
  frame_cnt_t cnt_q,    cnt_d;

  assign flush       = bus.FLUSH;
  assign pop         = b_vld_q && (level != '0) && !flush;
  assign bus.A_READY = !flush && (level != FULL_LVL);
  assign bus.B_READY = !flush && (!b_vld_q || pop);
  assign a_push      = bus.A_VALID && bus.A_READY;
  assign b_push      = bus.B_VALID && bus.B_READY;

  pair_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_fifo (
    .CLK    (CLK),
    .RESET_X(RESET_X),
    .wr_en  (a_push),
    .rd_en  (pop),
    .clr    (flush),
    .din    (bus.A_DATA),
    .dout   (fifo_dout),
    .level  (level)
  );

  always_comb begin
    b_vld_d  = b_vld_q;
    b_dat_d  = b_dat_q;
    out_en_d = pop;
    out_a_d  = out_a_q;
    out_b_d  = out_b_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    if (flush) begin
      b_vld_d = 1'b0;
      cnt_d   = '0;
    end else begin
      // A B beat landing in the same cycle as a pop refills the hold register.
      if (b_push) begin
        b_vld_d = 1'b1;
        b_dat_d = bus.B_DATA;
      end else if (pop) begin
        b_vld_d = 1'b0;
      end
      if (pop) begin
        out_a_d = fifo_dout;
        out_b_d = b_dat_q;
        done_d  = frame_is_last(cnt_q, bus.FRAME_LEN);
        cnt_d   = frame_cnt_next(cnt_q, bus.FRAME_LEN);
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      b_vld_q  <= 1'b0;
      b_dat_q  <= '0;
      out_en_q <= 1'b0;
      out_a_q  <= '0;
      out_b_q  <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      b_vld_q  <= b_vld_d;
      b_dat_q  <= b_dat_d;
      out_en_q <= out_en_d;
      out_a_q  <= out_a_d;
      out_b_q  <= out_b_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.OUT_EN     = out_en_q;
  assign bus.OUT_A      = out_a_q;
  assign bus.OUT_B      = out_b_q;
  assign bus.FRAME_DONE = done_q;
  assign bus.A_LEVEL    = level;

`ifdef Q_PAIR_STATS_EN
  logic [31:0] stat_pairs_q, stat_pairs_d;
  logic [AW:0] stat_hwm_q,   stat_hwm_d;

  // Stats survive FLUSH so they describe the whole run since reset.
  always_comb begin
    stat_pairs_d = stat_pairs_q;
    stat_hwm_d   = stat_hwm_q;
    if (pop && (stat_pairs_q != 32'hFFFF_FFFF)) stat_pairs_d = stat_pairs_q + 32'd1;
    if (level > stat_hwm_q) stat_hwm_d = level;
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      stat_pairs_q <= '0;
      stat_hwm_q   <= '0;
    end else begin
      stat_pairs_q <= stat_pairs_d;
      stat_hwm_q   <= stat_hwm_d;
    end
  end

  assign STAT_PAIRS = stat_pairs_q;
  assign STAT_A_HWM = stat_hwm_q;
`endif
endmodule

// File: tb/tb_q_add8_pair_buf.sv
// Directed and random stimulus against a queue-based pairing model.
module tb_q_add8_pair_buf;
  logic CLK = 1'b0;
  logic RESET_X;
  always #5 CLK = ~CLK;

  q_add8_pair_buf_if #(.AW(4)) bus ();

`ifdef Q_PAIR_STATS_EN
  logic [31:0] STAT_PAIRS;
  logic [4:0]  STAT_A_HWM;
`endif

  q_add8_pair_buf #(.DEPTH(16), .AW(4)) dut (
    .CLK    (CLK),
    .RESET_X(RESET_X),
    .bus    (bus)
`ifdef Q_PAIR_STATS_EN
    ,
    .STAT_PAIRS(STAT_PAIRS),
    .STAT_A_HWM(STAT_A_HWM)
`endif
  );

  // Reference model: bytes accepted but not yet paired, in arrival order.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int         cnt;
  int         flen;
  logic       e_en, e_done;
  logic [7:0] e_a, e_b;
  int         e_pairs;
  int         e_hwm;
  int         ndone;
  int         nvec, nerr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear(input bit full_reset);
    qa.delete();
    qb.delete();
    cnt    = 0;
    e_en   = 1'b0;
    e_done = 1'b0;
    if (full_reset) begin
      e_a     = 8'h00;
      e_b     = 8'h00;
      e_pairs = 0;
      e_hwm   = 0;
    end
  endtask

  // One clock: drive at edge+1, check readies at edge+2, check registered outputs after the next edge.
  task automatic tick(input bit av, input logic [7:0] ad, input bit bv, input logic [7:0] bd, input bit fl);
    bit pop, ea, eb;
    bus.A_VALID   = av;
    bus.A_DATA    = ad;
    bus.B_VALID   = bv;
    bus.B_DATA    = bd;
    bus.FLUSH     = fl;
    bus.FRAME_LEN = 16'(flen);
    #1;
    pop = !fl && (qa.size() > 0) && (qb.size() > 0);
    ea  = !fl && (qa.size() != 16);
    eb  = !fl && ((qb.size() == 0) || pop);
    chk("a_ready", 32'(bus.A_READY), 32'(ea));
    chk("b_ready", 32'(bus.B_READY), 32'(eb));
    if (fl) begin
      model_clear(1'b0);
    end else begin
      e_en   = pop;
      e_done = 1'b0;
      if (pop) begin
        e_a = qa.pop_front();
        e_b = qb.pop_front();
        e_pairs++;
        if (flen != 0 && cnt == flen - 1) begin
          e_done = 1'b1;
          cnt    = 0;
        end else begin
          cnt = (cnt + 1) % 65536;
        end
      end
      if (av && ea) qa.push_back(ad);
      if (bv && eb) qb.push_back(bd);
      if (qa.size() > e_hwm) e_hwm = qa.size();
    end
    @(posedge CLK);
    #1;
    chk("out_en",     32'(bus.OUT_EN),     32'(e_en));
    chk("out_a",      32'(bus.OUT_A),      32'(e_a));
    chk("out_b",      32'(bus.OUT_B),      32'(e_b));
    chk("frame_done", 32'(bus.FRAME_DONE), 32'(e_done));
    chk("a_level",    32'(bus.A_LEVEL),    32'(qa.size()));
    if (bus.FRAME_DONE === 1'b1) ndone++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear at once.
  task automatic apply_reset();
    bus.A_VALID = 1'b0;
    bus.B_VALID = 1'b0;
    bus.FLUSH   = 1'b0;
    RESET_X     = 1'b0;
    #1;
    model_clear(1'b1);
    chk("rst_out_en",     32'(bus.OUT_EN),     32'd0);
    chk("rst_out_a",      32'(bus.OUT_A),      32'd0);
    chk("rst_out_b",      32'(bus.OUT_B),      32'd0);
    chk("rst_frame_done", 32'(bus.FRAME_DONE), 32'd0);
    chk("rst_a_level",    32'(bus.A_LEVEL),    32'd0);
`ifdef Q_PAIR_STATS_EN
    chk("rst_stat_pairs", STAT_PAIRS,          32'd0);
    chk("rst_stat_hwm",   32'(STAT_A_HWM),     32'd0);
`endif
    @(posedge CLK);
    #1;
    RESET_X = 1'b1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    ndone = 0;
    flen = 4;
    bus.A_VALID = 1'b0;
    bus.A_DATA  = 8'h00;
    bus.B_VALID = 1'b0;
    bus.B_DATA  = 8'h00;
    bus.FLUSH   = 1'b0;
    bus.FRAME_LEN = 16'd4;
    RESET_X = 1'b0;
    @(posedge CLK);
    #1;
    apply_reset();

    // 1: single aligned pair, visible two cycles after acceptance
    tick(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
    chk("lat_c1_no_out", 32'(bus.OUT_EN), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("lat_c2_out_a", 32'(bus.OUT_A), 32'h11);
    chk("lat_c2_out_b", 32'(bus.OUT_B), 32'h22);
    idle(2);

    // 2: fill A FIFO, then drain with back-to-back B beats
    apply_reset();
    for (int i = 0; i < 16; i++) tick(1'b1, 8'(8'h40 + i), 1'b0, 8'h00, 1'b0);
    chk("full_level", 32'(bus.A_LEVEL), 32'd16);
    tick(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) tick(1'b0, 8'h00, 1'b1, 8'(8'h80 + i), 1'b0);
    idle(3);
    chk("drained_level", 32'(bus.A_LEVEL), 32'd0);
    tick(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
`ifdef Q_PAIR_STATS_EN
    idle(1);
    chk("stat_pairs", STAT_PAIRS, 32'(e_pairs));
    chk("stat_hwm",   32'(STAT_A_HWM), 32'(e_hwm));
`endif

    // 3: FRAME_LEN=3 over 7 pairs, then framing disabled
    flen = 3;
    ndone = 0;
    for (int i = 0; i < 7; i++) tick(1'b1, 8'(i), 1'b1, 8'(8'hA0 + i), 1'b0);
    idle(3);
    chk("done_count_len3", 32'(ndone), 32'd2);
    flen = 0;
    ndone = 0;
    for (int i = 0; i < 10; i++) tick(1'b1, 8'(8'h30 + i), 1'b1, 8'(8'hC0 + i), 1'b0);
    idle(3);
    chk("done_count_len0", 32'(ndone), 32'd0);

    // 4: FLUSH with level 5 and a held B beat; frame restarts afterwards
    flen = 2;
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h50 + i), 1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1, 8'h5B, 1'b0);
    tick(1'b1, 8'h77, 1'b1, 8'h78, 1'b1);
    chk("post_flush_level", 32'(bus.A_LEVEL), 32'd0);
    tick(1'b1, 8'h61, 1'b1, 8'h62, 1'b0);
    tick(1'b1, 8'h63, 1'b1, 8'h64, 1'b0);
    idle(3);

    // 5: reset mid-stream at level 7; nothing stale may emerge
    for (int i = 0; i < 7; i++) tick(1'b1, 8'(8'h90 + i), 1'b0, 8'h00, 1'b0);
    apply_reset();
    tick(1'b0, 8'h00, 1'b1, 8'hB1, 1'b0);
    idle(5);

    // 6: random traffic with occasional flushes and frame-length changes
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) flen = $urandom_range(0, 5);
      tick($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1, 8'($urandom),
           $urandom_range(0, 79) == 0);
    end
    idle(20);
`ifdef Q_PAIR_STATS_EN
    chk("stat_pairs_rand", STAT_PAIRS, 32'(e_pairs));
    chk("stat_hwm_rand",   32'(STAT_A_HWM), 32'(e_hwm));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
